// File: rtl/rx_pkg.sv
// Shared types and default constants for the serial receive timing block.
package rx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    RECEIVE,
    CHECK,
    LOAD
  } rx_state_t;

  localparam int RX_CLKS_PER_BIT = 10;
  localparam int RX_DATA_BITS    = 8;

endpackage

// File: rtl/rx_timing_ctrl_if.sv
// Control bundle between start detector, shift register, receive buffer
// and rx_timing_ctrl.
interface rx_timing_ctrl_if;

  logic start_bit_detected;
  logic stop_bit;
  logic serial_in;
  logic shift_strobe;
  logic enable_timer;
  logic sbc_clear;
  logic packet_done;
  logic load_buffer;
  logic framing_error;

  modport master (
    output start_bit_detected,
    output stop_bit,
    output serial_in,
    input  shift_strobe,
    input  enable_timer,
    input  sbc_clear,
    input  packet_done,
    input  load_buffer,
    input  framing_error
  );

  modport slave (
    input  start_bit_detected,
    input  stop_bit,
    input  serial_in,
    output shift_strobe,
    output enable_timer,
    output sbc_clear,
    output packet_done,
    output load_buffer,
    output framing_error
  );

endinterface

// File: rtl/flex_counter.sv
// Up counter 1..rollover_val with synchronous clear; restarts at 1
// after reaching rollover_val.
module flex_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         n_rst,
  input  logic         clear,
  input  logic         count_enable,
  input  logic [W-1:0] rollover_val,
  output logic [W-1:0] count_out
);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count_out <= '0;
    end else if (clear) begin
      count_out <= '0;
    end else if (count_enable) begin
      if (count_out == rollover_val) begin
        count_out <= W'(1);
      end else begin
        count_out <= count_out + W'(1);
      end
    end
  end

endmodule

// File: rtl/rx_timing_ctrl.sv
// Receive bit timing and frame control FSM.
// Optional start-bit recheck: define RX_START_VERIFY_EN.
module rx_timing_ctrl
  import rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = RX_CLKS_PER_BIT,
  parameter int DATA_BITS    = RX_DATA_BITS
) (
  input logic             clk,
  input logic             n_rst,
  rx_timing_ctrl_if.slave bus
);

  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam int BW = $clog2(DATA_BITS + 3);

  localparam logic [CW-1:0] BIT_END  = CW'(CLKS_PER_BIT);
  localparam logic [CW-1:0] MID      = CW'(CLKS_PER_BIT / 2);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS + 1);
  localparam logic [BW-1:0] BIT_ROLL = BW'(DATA_BITS + 2);

  rx_state_t     state;
  logic          fe;
  logic [CW-1:0] clk_cnt;
  logic [BW-1:0] bit_cnt;
  logic          timing;
  logic          cnt_clear;
  logic          at_mid;
  logic          bit_done;
  logic          at_stop;
  logic          glitch;

  assign timing    = (state == RECEIVE);
  assign cnt_clear = (state == START);
  assign at_mid    = timing && (clk_cnt == MID);
  assign bit_done  = timing && (clk_cnt == BIT_END);
  assign at_stop   = at_mid && (bit_cnt == LAST_BIT);

  // bit_cnt is 0 during the start bit, so its midpoint is never strobed
  flex_counter #(.W(CW)) u_clk_cnt (
    .clk          (clk),
    .n_rst        (n_rst),
    .clear        (cnt_clear),
    .count_enable (timing),
    .rollover_val (BIT_END),
    .count_out    (clk_cnt)
  );

  flex_counter #(.W(BW)) u_bit_cnt (
    .clk          (clk),
    .n_rst        (n_rst),
    .clear        (cnt_clear),
    .count_enable (bit_done),
    .rollover_val (BIT_ROLL),
    .count_out    (bit_cnt)
  );

`ifdef RX_START_VERIFY_EN
  assign glitch = at_mid && (bit_cnt == '0)
               && bus.serial_in;
`else
  logic unused_serial;
  assign unused_serial = bus.serial_in;
  assign glitch = 1'b0;
`endif

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state <= IDLE;
      fe    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.start_bit_detected) begin
            state <= START;
            fe    <= 1'b0;
          end
        end
        START: begin
          state <= RECEIVE;
        end
        RECEIVE: begin
          if (glitch) begin
            state <= IDLE;
          end else if (at_stop) begin
            state <= CHECK;
          end
        end
        CHECK: begin
          if (bus.stop_bit) begin
            state <= LOAD;
          end else begin
            state <= IDLE;
            fe    <= 1'b1;
          end
        end
        LOAD: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.shift_strobe  = at_mid && (bit_cnt != '0);
  assign bus.enable_timer  = timing;
  assign bus.sbc_clear     = cnt_clear;
  assign bus.packet_done   = (state == CHECK);
  assign bus.load_buffer   = (state == LOAD);
  assign bus.framing_error = fe;

endmodule

// File: tb/tb_rx_timing_ctrl.sv
// Randomized frame-level bench for rx_timing_ctrl.
// Expected outputs come from a cycle-offset model of the frame schedule.
module tb_rx_timing_ctrl;
  import rx_pkg::*;

  localparam int CPB  = RX_CLKS_PER_BIT;
  localparam int DB   = RX_DATA_BITS;
  localparam int HALF = CPB / 2;
  localparam int TS   = 2 + (DB + 1) * CPB + HALF;
  localparam int NF   = 30;
`ifdef RX_START_VERIFY_EN
  localparam bit VERIFY = 1'b1;
`else
  localparam bit VERIFY = 1'b0;
`endif

  logic clk = 1'b0;
  logic n_rst;

  rx_timing_ctrl_if bus();

  rx_timing_ctrl #(
    .CLKS_PER_BIT (CPB),
    .DATA_BITS    (DB)
  ) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs == exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d expected %0d (t=%0t)",
               tag, obs, exp, $time);
    end
  endtask

  task automatic cmp_all(input string tag, input bit sbc,
                         input bit en, input bit strb,
                         input bit pd, input bit ld,
                         input bit fe);
    chk({tag, ".sbc"}, int'(bus.sbc_clear), int'(sbc));
    chk({tag, ".en"}, int'(bus.enable_timer), int'(en));
    chk({tag, ".strb"}, int'(bus.shift_strobe), int'(strb));
    chk({tag, ".pd"}, int'(bus.packet_done), int'(pd));
    chk({tag, ".ld"}, int'(bus.load_buffer), int'(ld));
    chk({tag, ".fe"}, int'(bus.framing_error), int'(fe));
  endtask

  initial begin
    bit stop, glitch, do_rst, extra, abort, fe_state;
    bit e_strb, e_en, e_pd, e_ld, e_fe;
    int last, n, nstrb, gap;

    n_rst = 1'b0;
    bus.start_bit_detected = 1'b0;
    bus.stop_bit = 1'b0;
    bus.serial_in = 1'b0;
    repeat (3) @(negedge clk);
    cmp_all("reset", 0, 0, 0, 0, 0, 0);
    n_rst = 1'b1;
    fe_state = 1'b0;

    for (int f = 0; f < NF; f++) begin
      if (f == 1 || f == 4) stop = 1'b0;
      else if (f < 6) stop = 1'b1;
      else stop = ($urandom_range(0, 3) != 0);
      glitch = VERIFY && (f > 0) && ($urandom_range(0, 2) == 0);
      do_rst = (f == 5 || f == 17);
      extra  = (f == 2) || ($urandom_range(0, 3) == 0);
      if (glitch) last = 2 + HALF;
      else if (stop) last = TS + 2;
      else last = TS + 1;
      abort = 1'b0;
      nstrb = 0;

      for (int rel = 0; rel <= last && !abort; rel++) begin
        @(negedge clk);
        n = rel - 2;
        e_strb = !glitch && n >= CPB && (n % CPB) == HALF
              && (n / CPB) <= DB + 1;
        e_en = rel >= 2 && rel <= (glitch ? 2 + HALF : TS);
        e_pd = !glitch && rel == TS + 1;
        e_ld = !glitch && stop && rel == TS + 2;
        e_fe = (rel == 0) ? fe_state
             : (!glitch && !stop && rel >= TS + 2);
        if (bus.shift_strobe) nstrb++;
        cmp_all("frame", rel == 1, e_en, e_strb,
                e_pd, e_ld, e_fe);

        bus.start_bit_detected = (rel == 0) ||
          (extra && rel >= 1 &&
           ($urandom_range(0, 7) == 0 ||
            rel == TS + 1 || rel == last));
        bus.stop_bit = (rel == TS + 1) ? stop
                     : 1'($urandom_range(0, 1));
        if (VERIFY)
          bus.serial_in = (rel == 2 + HALF) ? glitch : 1'b0;
        else
          bus.serial_in = 1'($urandom_range(0, 1));

        if (do_rst && rel == 52) begin
          #2 n_rst = 1'b0;
          #1 cmp_all("rst_now", 0, 0, 0, 0, 0, 0);
          bus.start_bit_detected = 1'b0;
          repeat (2) @(negedge clk);
          cmp_all("rst_hold", 0, 0, 0, 0, 0, 0);
          n_rst = 1'b1;
          abort = 1'b1;
        end
      end

      if (abort) fe_state = 1'b0;
      else fe_state = !glitch && !stop;
      if (!abort) chk("nstrb", nstrb, glitch ? 0 : DB + 1);

      gap = abort ? 5 : $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) begin
        @(negedge clk);
        cmp_all("idle", 0, 0, 0, 0, 0, fe_state);
        bus.start_bit_detected = 1'b0;
        bus.stop_bit = 1'($urandom_range(0, 1));
        bus.serial_in = VERIFY ? 1'b0
                      : 1'($urandom_range(0, 1));
      end
    end

    @(negedge clk);
    cmp_all("final", 0, 0, 0, 0, 0, fe_state);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/rx_timing_ctrl.md
# rx_timing_ctrl

Receive timing and control unit for the serial receiver. After a start bit it times every bit period, emits one mid-bit `shift_strobe` per data and stop bit to the receive shift register, and checks the stop bit. It then either loads the receive buffer or flags a framing error. It is built from two counter instances and a small control FSM, and sits between the start-bit detector and the shift register / receive buffer.

## Interface
- `CLKS_PER_BIT`, 10: clock cycles per serial bit; legal range 4..255.
- `DATA_BITS`, 8: data bits per frame; legal range 5..9.
- `clk` in 1: single clock, all state on rising edge.
- `n_rst` in 1: reset, asynchronous, active-low.
- `start_bit_detected` in 1: one-cycle pulse from the start-bit detector.
- `stop_bit` in 1: stop-bit value from the shift register; valid the cycle after the last `shift_strobe`.
- `serial_in` in 1: synchronized line value; used only when `RX_START_VERIFY_EN` is defined.
- `shift_strobe` out 1: one-cycle pulse that shifts the register at mid-bit.
- `enable_timer` out 1: high while bits are being timed.
- `sbc_clear` out 1: one-cycle clear to the stop-bit checker at frame start.
- `packet_done` out 1: one-cycle pulse after the stop bit is sampled.
- `load_buffer` out 1: one-cycle pulse that writes the receive buffer.
- `framing_error` out 1: registered error flag; stays high until the next frame starts.

## Operation
- States are `IDLE`, `START`, `RECEIVE`, `CHECK` and `LOAD`.
- `IDLE`:
  - All pulse outputs are 0.
  - `start_bit_detected` = 1 moves the FSM to `START`.
- `START`, one cycle:
  - `sbc_clear` = 1.
  - `framing_error` clears to 0.
  - Both counters clear.
  - Next state is `RECEIVE`.
- `RECEIVE`:
  - `enable_timer` = 1.
  - T0 is the first `RECEIVE` cycle.
  - `shift_strobe` is high exactly at cycles T0 + k·CLKS_PER_BIT + CLKS_PER_BIT/2 (integer divide), for k = 1..DATA_BITS+1. These are the data bits followed by the stop bit; the start bit is not strobed.
  - Ts is the last strobe cycle (k = DATA_BITS+1). The FSM moves to `CHECK` at Ts+1.
- `CHECK`, one cycle:
  - `packet_done` = 1.
  - `stop_bit` = 0: `framing_error` is set and the FSM returns to `IDLE` without loading.
  - `stop_bit` = 1: the FSM moves to `LOAD`.
- `LOAD`, one cycle:
  - `load_buffer` = 1.
  - Next state is `IDLE`.
- `start_bit_detected` is ignored in every state except `IDLE`, including the cycle of `CHECK` or `LOAD`.
- Arithmetic:
  - The clock counter is ceil(log2(CLKS_PER_BIT+1)) bits wide.
  - The bit counter is ceil(log2(DATA_BITS+3)) bits wide.
  - Neither counter wraps inside a frame.

## Timing
- All outputs are registered or decoded from registered state; there are no combinational paths from input to output.
- Latency: `start_bit_detected` at cycle C gives `START` at C+1 and T0 = C+2.
- Frame length: `packet_done` = Ts+1 and `load_buffer` = Ts+2.
- Reset value of every output is 0, and the FSM is in `IDLE`.
- Reset asserted mid-frame: outputs go to 0 immediately and asynchronously, and counters clear. No partial `packet_done` or `load_buffer` follows after reset is released.
- `framing_error` remains high through `IDLE` until the next `START`.

## Configuration
- Macro: `RX_START_VERIFY_EN`.
- Defined:
  - `serial_in` is sampled at T0 + CLKS_PER_BIT/2, the start-bit midpoint.
  - If it is 1, the frame is a glitch: the FSM returns to `IDLE` on the next cycle.
  - A glitch frame produces no `shift_strobe`, `packet_done`, `load_buffer` or `framing_error`.
- Undefined: `serial_in` is ignored and the start bit is never rechecked.

## Structure
- Package `rx_pkg` holds:
  - the `rx_state_t` enum (`IDLE`, `START`, `RECEIVE`, `CHECK`, `LOAD`);
  - default constants `RX_CLKS_PER_BIT` = 10 and `RX_DATA_BITS` = 8.
- Sub-module: two instances of the team's existing `flex_counter`.
  - One counts clocks per bit.
  - The other counts bits.
  - The strobe cycles in Timing are normative; the rollover values and enables must be wired to meet them.

## Test plan
All scenarios use the defaults CLKS_PER_BIT = 10, DATA_BITS = 8.
1. Good frame, `start_bit_detected` at C:
   - `sbc_clear` at C+1.
   - Strobes at T0+15, 25, …, 95, which is 9 pulses.
   - `packet_done` at T0+96 and `load_buffer` at T0+97.
   - `framing_error` = 0.
2. Frame with `stop_bit` = 0 at T0+96:
   - `packet_done` pulses and `framing_error` rises at T0+97.
   - No `load_buffer`.
   - The next `start_bit_detected` clears the flag one cycle later.
3. Extra `start_bit_detected` pulses during `RECEIVE` and during `CHECK`:
   - The strobe schedule is unchanged.
   - No extra `START` occurs.
4. `n_rst` low at T0+50:
   - All outputs go to 0 immediately.
   - After release, the block stays in `IDLE` until the next `start_bit_detected`.
5. Back-to-back frames with `start_bit_detected` in the first `IDLE` cycle after `LOAD`:
   - The second frame's strobe schedule is exact, with no lost or extra pulses.
6. With `RX_START_VERIFY_EN` defined:
   - `serial_in` = 1 at T0+5 returns the FSM to `IDLE` with zero strobes.
   - `serial_in` = 0 at T0+5 gives the behaviour of scenario 1.
